// File: rtl/natv_bus_pkg.sv
// Shared types and constants for the native-bus timeout bridge.
package natv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } natv_req_t;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    // Watchdog counter width; a disabled watchdog still needs a legal 1-bit vector.
    function automatic int wdog_cnt_w(input int tmo_cyc);
        int w;
        w = $clog2(tmo_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_wdog_cnt.sv
// Downstream watchdog: counts enabled cycles and pulses expire on the last allowed one.
module bus_wdog_cnt
    import natv_bus_pkg::*;
#(
    parameter int TMO_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = wdog_cnt_w(TMO_CYC);

    generate
        if (TMO_CYC == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (clr_i) begin
                    r_cnt <= '0;
                end else if (en_i) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign expire_o = en_i && (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/natv_bus_tmo_bridge.sv
// Registered single-outstanding slice on the native core bus with a timeout watchdog
// that completes hung accesses with error data and records sticky error status.
module natv_bus_tmo_bridge
    import natv_bus_pkg::*;
#(
    parameter int          TMO_CYC   = 1024,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF,
    parameter int          ECNT_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    input  logic [31:0]       s_addr_i,
    input  logic [31:0]       s_wdata_i,
    input  logic [3:0]        s_wstrb_i,
    output logic [31:0]       s_rdata_o,
    output logic              s_ready_o,
    output logic              m_valid_o,
    output logic [31:0]       m_addr_o,
    output logic [31:0]       m_wdata_o,
    output logic [3:0]        m_wstrb_o,
    input  logic [31:0]       m_rdata_i,
    input  logic              m_ready_i,
    input  logic              clr_i,
    output logic              tmo_irq_o,
    output logic [31:0]       err_addr_o,
    output logic [ECNT_W-1:0] err_cnt_o
);

    state_t            r_state;
    natv_req_t         r_req;
    logic              r_m_valid;
    logic              r_s_ready;
    logic [31:0]       r_s_rdata;
    logic              r_tmo_irq;
    logic [31:0]       r_err_addr;
    logic [ECNT_W-1:0] r_err_cnt;

    logic              w_capture;
    logic              w_in_req;
    logic              w_expire;
    logic              w_timeout;
    logic [ECNT_W-1:0] w_cnt_base;
    logic [ECNT_W-1:0] w_cnt_inc;

    // The core still holds valid during its ready cycle, so that cycle must not start a new access.
    assign w_capture = (r_state == IDLE) && s_valid_i && !r_s_ready;
    assign w_in_req  = (r_state == REQ);
    // A slave answering on the expiry cycle still gets its data through.
    assign w_timeout = w_expire && !m_ready_i;

    bus_wdog_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (w_capture),
        .en_i     (w_in_req),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b0;
            r_s_rdata <= '0;
        end else begin
            r_s_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_s_rdata <= '0;
                    if (w_capture) begin
                        r_req.addr  <= s_addr_i;
                        r_req.wdata <= s_wdata_i;
                        r_req.wstrb <= s_wstrb_i;
                        r_m_valid   <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (m_ready_i) begin
                        r_s_rdata <= m_rdata_i;
                        r_m_valid <= 1'b0;
                        r_state   <= RESP;
                    end else if (w_timeout) begin
                        r_s_rdata <= ERR_RDATA;
                        r_m_valid <= 1'b0;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_s_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_m_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // A clear in the same cycle as a timeout restarts the count from the new event.
    assign w_cnt_base = clr_i ? '0 : r_err_cnt;
    assign w_cnt_inc  = (&w_cnt_base) ? w_cnt_base : w_cnt_base + ECNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_irq  <= 1'b0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else if (w_timeout) begin
            r_tmo_irq  <= 1'b1;
            r_err_addr <= r_req.addr;
            r_err_cnt  <= w_cnt_inc;
        end else if (clr_i) begin
            r_tmo_irq  <= 1'b0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end
    end

    assign s_rdata_o  = r_s_rdata;
    assign s_ready_o  = r_s_ready;
    assign m_valid_o  = r_m_valid;
    assign m_addr_o   = r_req.addr;
    assign m_wdata_o  = r_req.wdata;
    assign m_wstrb_o  = r_req.wstrb;
    assign tmo_irq_o  = r_tmo_irq;
    assign err_addr_o = r_err_addr;
    assign err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_natv_bus_tmo_bridge.sv
// Directed bench for natv_bus_tmo_bridge with TMO_CYC=16 and an 8-bit error counter.
module tb_natv_bus_tmo_bridge;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        s_valid_i = 1'b0;
    logic [31:0] s_addr_i = '0;
    logic [31:0] s_wdata_i = '0;
    logic [3:0]  s_wstrb_i = '0;
    logic [31:0] s_rdata_o;
    logic        s_ready_o;
    logic        m_valid_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic [31:0] m_rdata_i = '0;
    logic        m_ready_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        tmo_irq_o;
    logic [31:0] err_addr_o;
    logic [7:0]  err_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    natv_bus_tmo_bridge #(
        .TMO_CYC   (TMO),
        .ERR_RDATA (32'hDEAD_BEEF),
        .ECNT_W    (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_valid_i  (s_valid_i),
        .s_addr_i   (s_addr_i),
        .s_wdata_i  (s_wdata_i),
        .s_wstrb_i  (s_wstrb_i),
        .s_rdata_o  (s_rdata_o),
        .s_ready_o  (s_ready_o),
        .m_valid_o  (m_valid_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_wstrb_o  (m_wstrb_o),
        .m_rdata_i  (m_rdata_i),
        .m_ready_i  (m_ready_i),
        .clr_i      (clr_i),
        .tmo_irq_o  (tmo_irq_o),
        .err_addr_o (err_addr_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One core access. Cycle k is the k-th cycle after the one in which s_valid_i rose.
    // rdy_cyc/clr_cyc: cycle in which m_ready_i/clr_i are driven high (0 = never).
    task automatic access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int rdy_cyc, input int clr_cyc,
                          input logic [31:0] slv_rd, input int exp_lat,
                          input logic [31:0] exp_rd, input int exp_vcyc, input bit quiet);
        int          lat;
        int          nvalid;
        int          nbad;
        logic [31:0] rd;
        lat = -1; nvalid = 0; nbad = 0; rd = '0;
        s_addr_i = addr; s_wdata_i = wdata; s_wstrb_i = wstrb; s_valid_i = 1'b1;
        for (int k = 1; k <= TMO + 24 && lat < 0; k++) begin
            tick();
            m_ready_i = (k == rdy_cyc);
            m_rdata_i = slv_rd;
            clr_i     = (k == clr_cyc);
            if (m_valid_o) begin
                nvalid++;
                if (m_addr_o !== addr || m_wdata_o !== wdata || m_wstrb_o !== wstrb) nbad++;
            end
            if (s_ready_o) begin
                lat = k;
                rd  = s_rdata_o;
            end
        end
        m_ready_i = 1'b0;
        clr_i     = 1'b0;
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".rdata"}, rd, exp_rd);
        chk({name, ".mvalid_cycles"}, nvalid, exp_vcyc);
        chk({name, ".m_stable_bad"}, nbad, 0);
        tick();
        s_valid_i = 1'b0;
        chk({name, ".ready_single"}, s_ready_o, 0);
        chk({name, ".no_recapture"}, m_valid_o, 0);
        chk({name, ".rdata_cleared"}, s_rdata_o, 0);
        if (!quiet)
            $display("txn %s addr=%h wstrb=%h latency=%0d rdata=%h irq=%0b ecnt=%0d",
                     name, addr, wstrb, lat, rd, tmo_irq_o, err_cnt_o);
    endtask

    initial begin
        tick();
        tick();
        chk("rst.m_valid", m_valid_o, 0);
        chk("rst.s_ready", s_ready_o, 0);
        chk("rst.s_rdata", s_rdata_o, 0);
        chk("rst.m_addr", m_addr_o, 0);
        chk("rst.irq", tmo_irq_o, 0);
        chk("rst.ecnt", err_cnt_o, 0);
        rst_i = 1'b0;
        tick();

        access("read1", 32'h0100_0004, 32'h0, 4'h0, 1, 0, 32'h1234_5678, 3, 32'h1234_5678, 1, 1'b0);
        chk("read1.irq", tmo_irq_o, 0);

        access("write5", 32'h0300_0010, 32'hCAFE_F00D, 4'hF, 5, 0, 32'h0, 7, 32'h0, 5, 1'b0);
        chk("write5.irq", tmo_irq_o, 0);

        access("tmo_read", 32'h0400_0000, 32'h0, 4'h0, 0, 0, 32'h5555_AAAA, TMO + 2,
               32'hDEAD_BEEF, TMO, 1'b0);
        chk("tmo_read.irq", tmo_irq_o, 1);
        chk("tmo_read.err_addr", err_addr_o, 32'h0400_0000);
        chk("tmo_read.ecnt", err_cnt_o, 1);
        // Now in cycle 19; a late slave ready at cycle 25 must be ignored.
        for (int i = 0; i < 6; i++) tick();
        m_ready_i = 1'b1;
        m_rdata_i = 32'h7777_7777;
        tick();
        m_ready_i = 1'b0;
        chk("late_rdy.m_valid", m_valid_o, 0);
        chk("late_rdy.s_ready", s_ready_o, 0);
        chk("late_rdy.s_rdata", s_rdata_o, 0);
        chk("late_rdy.ecnt", err_cnt_o, 1);
        tick();
        chk("late_rdy.s_ready2", s_ready_o, 0);

        access("rdy_on_expiry", 32'h0400_0100, 32'h0, 4'h0, TMO, 0, 32'hA5A5_0016, TMO + 2,
               32'hA5A5_0016, TMO, 1'b0);
        chk("rdy_on_expiry.ecnt", err_cnt_o, 1);
        chk("rdy_on_expiry.err_addr", err_addr_o, 32'h0400_0000);

        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("clr.irq", tmo_irq_o, 0);
        chk("clr.err_addr", err_addr_o, 0);
        chk("clr.ecnt", err_cnt_o, 0);

        for (int i = 0; i < 300; i++)
            access("bulk_tmo", 32'h0500_0000 + 32'(i * 4), 32'h0, 4'h0, 0, 0, 32'h0, TMO + 2,
                   32'hDEAD_BEEF, TMO, 1'b1);
        $display("txn bulk_tmo x300 irq=%0b ecnt=%0d err_addr=%h", tmo_irq_o, err_cnt_o, err_addr_o);
        chk("sat.ecnt", err_cnt_o, 255);
        chk("sat.err_addr", err_addr_o, 32'h0500_04AC);
        chk("sat.irq", tmo_irq_o, 1);

        access("clr_on_tmo", 32'h0600_0000, 32'h0, 4'h0, 0, TMO, 32'h0, TMO + 2,
               32'hDEAD_BEEF, TMO, 1'b0);
        chk("clr_on_tmo.irq", tmo_irq_o, 1);
        chk("clr_on_tmo.ecnt", err_cnt_o, 1);
        chk("clr_on_tmo.err_addr", err_addr_o, 32'h0600_0000);

        s_addr_i = 32'h0700_0000; s_wdata_i = '0; s_wstrb_i = 4'h0; s_valid_i = 1'b1;
        tick();
        chk("mid_rst.m_valid_before", m_valid_o, 1);
        tick();
        rst_i = 1'b1;
        #1;
        chk("mid_rst.m_valid", m_valid_o, 0);
        chk("mid_rst.s_ready", s_ready_o, 0);
        chk("mid_rst.m_addr", m_addr_o, 0);
        chk("mid_rst.irq", tmo_irq_o, 0);
        chk("mid_rst.ecnt", err_cnt_o, 0);
        s_valid_i = 1'b0;
        tick();
        chk("mid_rst.no_resp", s_ready_o, 0);
        rst_i = 1'b0;
        tick();
        access("post_rst_read", 32'h0100_0020, 32'h0, 4'h0, 2, 0, 32'h0BAD_F00D, 4,
               32'h0BAD_F00D, 2, 1'b0);
        chk("post_rst.irq", tmo_irq_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
